control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1 bit: begin program execution from IDLE.
REQ-004 SHALL have port opcode, input, 8 bits: instruction register upper byte [15:8], valid in DECODE.
REQ-005 SHALL have port zero_flag, input, 1 bit: zero flag from the downstream ALU.
REQ-006 SHALL have port alu_sel, output, 4 bits: ALU operation select.
REQ-007 SHALL have port b_sel, output, 1 bit: ALU B operand source (0 = register, 1 = immediate).
REQ-008 SHALL have port ac_src, output, 1 bit: accumulator source (0 = ALU out, 1 = memory data).
REQ-009 SHALL have ports ir_load, pc_inc, pc_load, ac_load, mem_rd and mem_wr, outputs, 1 bit each: datapath strobes.
REQ-010 SHALL have port done, output, 1 bit: program finished.
REQ-011 SHALL have port illegal, output, 1 bit: sticky flag, undefined opcode seen.

Function
REQ-012 SHALL implement a Moore FSM; outputs SHALL be registered or decoded from state only, except the pc_load decode in REQ-019.
REQ-013 SHALL use states IDLE, FETCH, FETCH_WAIT, DECODE, EXEC, ALU_WAIT, MEM_RD, MEM_WAIT, MEM_WR, JUMP and HALT; each state lasts exactly 1 cycle, except IDLE and HALT.
REQ-014 IDLE: all strobes 0; go to FETCH on the cycle after start = 1 is sampled.
REQ-015 FETCH: mem_rd = 1; go to FETCH_WAIT. FETCH_WAIT: ir_load = 1 and pc_inc = 1; go to DECODE.
REQ-016 DECODE: no strobes asserted; branch on opcode as follows.
- 0x00 NOP: go to FETCH.
- 0x01 INCR, 0x02 ADDR, 0x03 ADDI, 0x04 SUBR, 0x05 SUBI, 0x06 SHL, 0x07 SHR, 0x08 OR: go to EXEC.
- 0x09 LOAD: go to MEM_RD.
- 0x0A STORE: go to MEM_WR.
- 0x0B JMPZ and 0x0C JMP: go to JUMP.
- 0x0F END: go to HALT.
- Any other value: set illegal and go to FETCH, treating the instruction as a NOP.
REQ-017 alu_sel mapping SHALL be:
- INCR = 0000.
- ADDR/ADDI = 0001.
- SUBR/SUBI = 0010.
- SHL = 0011.
- SHR = 0100.
- OR = 0101.
- In all other states alu_sel = 0000.
b_sel = 1 only for ADDI and SUBI; otherwise b_sel = 0.
REQ-018 EXEC: drive alu_sel and b_sel, which the ALU registers at the end of EXEC; go to ALU_WAIT. ALU_WAIT: hold alu_sel and b_sel, assert ac_load = 1 with ac_src = 0; go to FETCH. ALU instruction latency from FETCH entry SHALL be 5 cycles.
REQ-019 JUMP:
- JMP: pc_load = 1.
- JMPZ: pc_load = zero_flag as sampled in the JUMP cycle.
- Go to FETCH in both cases.
REQ-020 MEM_RD: mem_rd = 1; go to MEM_WAIT. MEM_WAIT: ac_load = 1 with ac_src = 1; go to FETCH.
REQ-021 MEM_WR: mem_wr = 1 for exactly 1 cycle; go to FETCH.
REQ-022 HALT: done = 1, all strobes 0; remain in HALT until rst, ignoring start.
REQ-023 The following pairs SHALL never be asserted in the same cycle: mem_rd and mem_wr; pc_inc and pc_load.
REQ-024 start SHALL be ignored in every state except IDLE.
REQ-025 illegal SHALL stay 1 until rst once set, and setting it SHALL not stop execution.
REQ-026 The controller SHALL assume the opcode is stable from the FETCH_WAIT edge through DECODE.

Reset
REQ-027 When rst = 1 is sampled, the next state SHALL be IDLE from any state, including mid-instruction.
REQ-028 After reset, every output SHALL be 0: alu_sel = 0000, b_sel = 0, ac_src = 0, all strobes 0, done = 0, illegal = 0.
REQ-029 rst SHALL take priority over start in the same cycle.
REQ-030 No memory or accumulator strobe SHALL be asserted in the cycle after rst is sampled.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
- Start with opcode 0x03 -> ir_load/pc_inc in cycle 2; alu_sel = 0001 and b_sel = 1 in cycles 4-5; ac_load = 1 in cycle 5; FETCH again in cycle 6.
- Opcode 0x0B with zero_flag = 1, then 0x0B with zero_flag = 0 -> pc_load = 1 for 1 cycle in the first JUMP only, and never together with pc_inc.
- Opcode 0x09, then 0x0A -> mem_rd, then ac_load with ac_src = 1; mem_wr for exactly 1 cycle; mem_rd and mem_wr never overlap.
- Opcode 0x0F, then start pulses in HALT -> done = 1 held indefinitely, no strobes.
- Opcode 0xA5 -> illegal = 1 stays set; next fetch proceeds normally; rst clears illegal.
- rst asserted during ALU_WAIT together with start = 1 -> next cycle is IDLE, all outputs 0, no ac_load.

Source files
------------

// File: rtl/control_unit.sv
// Multi-cycle processor controller: Moore FSM that sequences fetch, decode,
// ALU, memory and jump steps. Strobes are decoded from state, except pc_load.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] opcode,
  input  logic       zero_flag,
  output logic [3:0] alu_sel,
  output logic       b_sel,
  output logic       ac_src,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       ac_load,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       done,
  output logic       illegal
);

  typedef enum logic [3:0] {
    IDLE, FETCH, FETCH_WAIT, DECODE, EXEC, ALU_WAIT,
    MEM_RD, MEM_WAIT, MEM_WR, JUMP, HALT
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_op;
  logic       r_illegal;
  logic       w_set_illegal;
  logic [3:0] w_alu_sel;
  logic       w_b_sel;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_op      <= 8'h00;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_next_state;
      // Opcode is only guaranteed during DECODE, so keep a copy for EXEC/ALU_WAIT/JUMP
      if (r_state == DECODE) r_op <= opcode;
      if (w_set_illegal) r_illegal <= 1'b1;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_set_illegal = 1'b0;
    case (r_state)
      IDLE:       if (start) w_next_state = FETCH;
      FETCH:      w_next_state = FETCH_WAIT;
      FETCH_WAIT: w_next_state = DECODE;
      DECODE: begin
        case (opcode)
          8'h00:                          w_next_state = FETCH;
          8'h01, 8'h02, 8'h03, 8'h04,
          8'h05, 8'h06, 8'h07, 8'h08:     w_next_state = EXEC;
          8'h09:                          w_next_state = MEM_RD;
          8'h0A:                          w_next_state = MEM_WR;
          8'h0B, 8'h0C:                   w_next_state = JUMP;
          8'h0F:                          w_next_state = HALT;
          default: begin
            w_set_illegal = 1'b1;
            w_next_state  = FETCH;
          end
        endcase
      end
      EXEC:       w_next_state = ALU_WAIT;
      ALU_WAIT:   w_next_state = FETCH;
      MEM_RD:     w_next_state = MEM_WAIT;
      MEM_WAIT:   w_next_state = FETCH;
      MEM_WR:     w_next_state = FETCH;
      JUMP:       w_next_state = FETCH;
      HALT:       w_next_state = HALT;
      default:    w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_alu_sel = 4'b0000;
    w_b_sel   = 1'b0;
    case (r_op)
      8'h02:   w_alu_sel = 4'b0001;
      8'h03: begin w_alu_sel = 4'b0001; w_b_sel = 1'b1; end
      8'h04:   w_alu_sel = 4'b0010;
      8'h05: begin w_alu_sel = 4'b0010; w_b_sel = 1'b1; end
      8'h06:   w_alu_sel = 4'b0011;
      8'h07:   w_alu_sel = 4'b0100;
      8'h08:   w_alu_sel = 4'b0101;
      default: w_alu_sel = 4'b0000;
    endcase
  end

  always_comb begin
    alu_sel = 4'b0000;
    b_sel   = 1'b0;
    ac_src  = 1'b0;
    ir_load = 1'b0;
    pc_inc  = 1'b0;
    pc_load = 1'b0;
    ac_load = 1'b0;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    done    = 1'b0;
    illegal = r_illegal;
    case (r_state)
      FETCH:      mem_rd = 1'b1;
      FETCH_WAIT: begin ir_load = 1'b1; pc_inc = 1'b1; end
      EXEC: begin
        alu_sel = w_alu_sel;
        b_sel   = w_b_sel;
      end
      ALU_WAIT: begin
        alu_sel = w_alu_sel;
        b_sel   = w_b_sel;
        ac_load = 1'b1;
      end
      MEM_RD:     mem_rd = 1'b1;
      MEM_WAIT:   begin ac_load = 1'b1; ac_src = 1'b1; end
      MEM_WR:     mem_wr = 1'b1;
      // Only JMP (0x0C) and JMPZ (0x0B) reach JUMP; JMPZ uses the live zero flag
      JUMP:       pc_load = (r_op == 8'h0C) || zero_flag;
      HALT:       done = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed scoreboard bench for control_unit: the driver pushes the expected
// output word for every cycle it drives; a negedge monitor pops and compares.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] opcode;
  logic       zero_flag;
  logic [3:0] alu_sel;
  logic       b_sel, ac_src, ir_load, pc_inc, pc_load, ac_load;
  logic       mem_rd, mem_wr, done, illegal;

  control_unit dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .zero_flag(zero_flag),
    .alu_sel(alu_sel), .b_sel(b_sel), .ac_src(ac_src), .ir_load(ir_load),
    .pc_inc(pc_inc), .pc_load(pc_load), .ac_load(ac_load), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .done(done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {alu_sel[3:0], b_sel, ac_src, ir_load, pc_inc, pc_load, ac_load, mem_rd, mem_wr, done, illegal}
  localparam logic [13:0] E_ZERO  = 14'h0000;
  localparam logic [13:0] E_ILL   = 14'h0001;
  localparam logic [13:0] E_DONE  = 14'h0002;
  localparam logic [13:0] E_MWR   = 14'h0004;
  localparam logic [13:0] E_FETCH = 14'h0008;
  localparam logic [13:0] E_ACL   = 14'h0010;
  localparam logic [13:0] E_PCL   = 14'h0020;
  localparam logic [13:0] E_FW    = 14'h00C0;
  localparam logic [13:0] E_ACSRC = 14'h0100;
  localparam logic [13:0] E_BSEL  = 14'h0200;
  localparam logic [13:0] E_ADD   = 14'h0400;
  localparam logic [13:0] E_SHR   = 14'h1000;

  typedef struct {
    logic [13:0] exp;
    string       name;
  } sb_item_t;

  sb_item_t sb[$];
  int n_applied = 0;
  int n_miscompares = 0;

  wire [13:0] w_obs = {alu_sel, b_sel, ac_src, ir_load, pc_inc, pc_load, ac_load,
                       mem_rd, mem_wr, done, illegal};

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_item_t it;
      it = sb.pop_front();
      n_applied++;
      if (w_obs !== it.exp) begin
        n_miscompares++;
        $display("FAIL %s: got %b, expected %b", it.name, w_obs, it.exp);
      end else begin
        $display("ok   %s: %b", it.name, w_obs);
      end
      if (mem_rd && mem_wr) begin
        n_miscompares++;
        $display("FAIL %s: mem_rd and mem_wr both 1, expected never together", it.name);
      end
      if (pc_inc && pc_load) begin
        n_miscompares++;
        $display("FAIL %s: pc_inc and pc_load both 1, expected never together", it.name);
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic [7:0] op,
                      input logic zf, input logic [13:0] e, input string nm);
    sb_item_t it;
    @(posedge clk);
    #1;
    rst       = r;
    start     = s;
    opcode    = op;
    zero_flag = zf;
    it.exp    = e;
    it.name   = nm;
    sb.push_back(it);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = 8'h00; zero_flag = 1'b0;
    repeat (2) @(posedge clk);

    step(1, 0, 8'h00, 0, E_ZERO, "reset_idle");
    step(0, 1, 8'h00, 0, E_ZERO, "idle_start");
    // ADDI
    step(0, 0, 8'h03, 0, E_FETCH, "addi_c1_fetch");
    step(0, 0, 8'h03, 0, E_FW, "addi_c2_fetchwait");
    step(0, 0, 8'h03, 0, E_ZERO, "addi_c3_decode");
    step(0, 0, 8'h03, 0, E_ADD | E_BSEL, "addi_c4_exec");
    step(0, 0, 8'h03, 0, E_ADD | E_BSEL | E_ACL, "addi_c5_aluwait");
    // JMPZ taken, then not taken
    step(0, 0, 8'h0B, 1, E_FETCH, "addi_c6_fetch");
    step(0, 0, 8'h0B, 1, E_FW, "jmpz1_fetchwait");
    step(0, 0, 8'h0B, 1, E_ZERO, "jmpz1_decode");
    step(0, 0, 8'h0B, 1, E_PCL, "jmpz1_jump_taken");
    step(0, 0, 8'h0B, 0, E_FETCH, "jmpz0_fetch");
    step(0, 0, 8'h0B, 0, E_FW, "jmpz0_fetchwait");
    step(0, 0, 8'h0B, 0, E_ZERO, "jmpz0_decode");
    step(0, 0, 8'h0B, 0, E_ZERO, "jmpz0_jump_not_taken");
    // LOAD then STORE
    step(0, 0, 8'h09, 0, E_FETCH, "load_fetch");
    step(0, 0, 8'h09, 0, E_FW, "load_fetchwait");
    step(0, 0, 8'h09, 0, E_ZERO, "load_decode");
    step(0, 0, 8'h09, 0, E_FETCH, "load_memrd");
    step(0, 0, 8'h09, 0, E_ACL | E_ACSRC, "load_memwait");
    step(0, 0, 8'h0A, 0, E_FETCH, "store_fetch");
    step(0, 0, 8'h0A, 0, E_FW, "store_fetchwait");
    step(0, 0, 8'h0A, 0, E_ZERO, "store_decode");
    step(0, 0, 8'h0A, 0, E_MWR, "store_memwr");
    // Illegal opcode, then INCR continues with illegal held
    step(0, 0, 8'hA5, 0, E_FETCH, "ill_fetch");
    step(0, 0, 8'hA5, 0, E_FW, "ill_fetchwait");
    step(0, 0, 8'hA5, 0, E_ZERO, "ill_decode");
    step(0, 0, 8'h01, 0, E_FETCH | E_ILL, "incr_fetch_ill_set");
    step(0, 0, 8'h01, 0, E_FW | E_ILL, "incr_fetchwait");
    step(0, 0, 8'h01, 0, E_ILL, "incr_decode");
    step(0, 0, 8'h01, 0, E_ILL, "incr_exec");
    step(0, 0, 8'h01, 0, E_ACL | E_ILL, "incr_aluwait");
    // SHR interrupted by reset+start in ALU_WAIT
    step(0, 0, 8'h07, 0, E_FETCH | E_ILL, "shr_fetch");
    step(0, 0, 8'h07, 0, E_FW | E_ILL, "shr_fetchwait");
    step(0, 0, 8'h07, 0, E_ILL, "shr_decode");
    step(0, 0, 8'h07, 0, E_SHR | E_ILL, "shr_exec");
    step(1, 1, 8'h07, 0, E_SHR | E_ACL | E_ILL, "shr_aluwait_rst");
    step(0, 0, 8'h00, 0, E_ZERO, "after_rst_idle");
    step(0, 1, 8'h00, 0, E_ZERO, "idle_start2");
    // END then start pulses in HALT
    step(0, 0, 8'h0F, 0, E_FETCH, "end_fetch");
    step(0, 0, 8'h0F, 0, E_FW, "end_fetchwait");
    step(0, 0, 8'h0F, 0, E_ZERO, "end_decode");
    step(0, 1, 8'h0F, 0, E_DONE, "halt_start1");
    step(0, 0, 8'h0F, 0, E_DONE, "halt_hold1");
    step(0, 1, 8'h0F, 0, E_DONE, "halt_start2");
    step(0, 0, 8'h0F, 0, E_DONE, "halt_hold2");
    step(1, 0, 8'h0F, 0, E_DONE, "halt_rst");
    step(0, 0, 8'h00, 0, E_ZERO, "final_idle");

    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      n_miscompares++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miscompares);
    $finish;
  end

endmodule
